// File: rtl/guvm_instr_mem_responder_pkg.sv
// Shared constants, the pipeline entry type and the parameter-legality check
// for the GUVM instruction-memory responder.
package guvm_mem_pkg;

    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;
    localparam int unsigned RESP_LAT_MIN = 1;
    localparam int unsigned RESP_LAT_MAX = 4;

    typedef struct packed {
        logic valid;
    } pipe_entry_t;

    // Depth must be a power of two so the pointers wrap for free.
    function automatic bit params_legal(
        input int unsigned data_w,
        input int unsigned addr_w,
        input int unsigned fifo_depth,
        input int unsigned resp_lat,
        input int unsigned max_out
    );
        return (data_w > 0) && (addr_w > 0) &&
               (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0) &&
               (resp_lat >= RESP_LAT_MIN) && (resp_lat <= RESP_LAT_MAX) &&
               (max_out >= 1) && (max_out <= resp_lat + 1);
    endfunction

endpackage

// File: rtl/guvm_instr_mem_responder_if.sv
// OBI-style instruction fetch port between the core (master) and the
// memory responder (slave).
interface guvm_instr_mem_responder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              instr_req_i;
    logic [ADDR_W-1:0] instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [DATA_W-1:0] instr_rdata_o;

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o
    );

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o
    );
endinterface

// File: rtl/guvm_instr_mem_responder_fifo.sv
// Synchronous instruction-word FIFO with flush; push is refused when full and
// pop is ignored when empty.
module guvm_sync_fifo
    import guvm_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              push_en;
    logic              pop_en;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/guvm_instr_mem_responder.sv
// Instruction-memory responder: grant stalls, fixed response latency and an
// outstanding limit. Optional sequential-address check: GUVM_SEQ_ADDR_CHECK_EN.
module guvm_instr_mem_responder
    import guvm_mem_pkg::*;
#(
    parameter int unsigned      DATA_W     = 32,
    parameter int unsigned      ADDR_W     = 32,
    parameter int unsigned      FIFO_DEPTH = 8,
    parameter int unsigned      RESP_LAT   = 1,
    parameter int unsigned      MAX_OUT    = 2,
    parameter int unsigned      GNT_STALL  = 0,
    parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_WORD_DEF)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_valid_i,
    input  logic [DATA_W-1:0]             push_data_i,
    output logic                          push_ready_o,
    input  logic                          flush_i,
    guvm_instr_mem_responder_if.slave     bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [$clog2(MAX_OUT):0]      outstanding_o,
    output logic                          underrun_o,
    output logic                          addr_err_o
);

    localparam int unsigned OW = $clog2(MAX_OUT) + 1;
    localparam int unsigned SW = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;

    if (!params_legal(DATA_W, ADDR_W, FIFO_DEPTH, RESP_LAT, MAX_OUT)) begin : g_param_err
        $error("guvm_instr_mem_responder: illegal parameter combination");
    end

    pipe_entry_t [RESP_LAT-1:0] pipe;
    logic [OW-1:0]              outstanding;
    logic [SW-1:0]              stall_cnt;
    logic                       underrun;
    logic [DATA_W-1:0]          rdata_q;
    logic [DATA_W-1:0]          rdata_now;
    logic                       gnt;
    logic                       rvalid;
    logic                       push_ready;
    logic [DATA_W-1:0]          fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;

    assign gnt        = bus.instr_req_i && !rst_i && (outstanding < OW'(MAX_OUT)) &&
                        (stall_cnt == '0);
    assign rvalid     = pipe[RESP_LAT-1].valid;
    assign push_ready = !fifo_full && !rst_i;
    assign rdata_now  = fifo_empty ? NOP_WORD : fifo_head;

    guvm_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_valid_i && push_ready),
        .push_data (push_data_i),
        .pop       (rvalid),
        .flush     (flush_i),
        .head      (fifo_head),
        .count     (fifo_count_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe <= '0;
        end else begin
            pipe[0].valid <= gnt;
            for (int unsigned i = 1; i < RESP_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
            stall_cnt   <= '0;
            underrun    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            case ({gnt, rvalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (gnt) stall_cnt <= SW'(GNT_STALL);
            else if (stall_cnt != '0) stall_cnt <= stall_cnt - 1'b1;
            if (rvalid) rdata_q <= rdata_now;
            // An underrun in the flush cycle is a fresh event, so it survives the clear.
            if (rvalid && fifo_empty) underrun <= 1'b1;
            else if (flush_i) underrun <= 1'b0;
        end
    end

    assign bus.instr_gnt_o    = gnt;
    assign bus.instr_rvalid_o = rvalid;
    assign bus.instr_rdata_o  = rvalid ? rdata_now : rdata_q;
    assign push_ready_o       = push_ready;
    assign outstanding_o      = outstanding;
    assign underrun_o         = underrun;

`ifdef GUVM_SEQ_ADDR_CHECK_EN
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_valid;
    logic              addr_err;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            exp_addr  <= '0;
            exp_valid <= 1'b0;
            addr_err  <= 1'b0;
        end else if (gnt) begin
            if (exp_valid && (bus.instr_addr_i != exp_addr)) addr_err <= 1'b1;
            exp_addr  <= bus.instr_addr_i + ADDR_W'(4);
            exp_valid <= 1'b1;
        end
    end

    assign addr_err_o = addr_err;
`else
    logic unused_addr;
    assign unused_addr = ^bus.instr_addr_i;
    assign addr_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_guvm_instr_mem_responder.sv
// Randomized bench for two responder configurations sharing one stimulus,
// checked against a queue-based timing model.
module tb_guvm_instr_mem_responder;
    import guvm_mem_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, push_valid, flush, req;
    logic [31:0] push_data, addr;

    always #5 clk = ~clk;

    guvm_instr_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
    guvm_instr_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
    assign bus0.instr_req_i  = req;
    assign bus0.instr_addr_i = addr;
    assign bus1.instr_req_i  = req;
    assign bus1.instr_addr_i = addr;

    logic       ready0, und0, aerr0, ready1, und1, aerr1;
    logic [2:0] cnt0;
    logic [3:0] cnt1;
    logic [1:0] out0, out1;

    guvm_instr_mem_responder #(
        .DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(4), .RESP_LAT(3), .MAX_OUT(2), .GNT_STALL(0)
    ) u0 (
        .clk_i(clk), .rst_i(rst), .push_valid_i(push_valid), .push_data_i(push_data),
        .push_ready_o(ready0), .flush_i(flush), .bus(bus0), .fifo_count_o(cnt0),
        .outstanding_o(out0), .underrun_o(und0), .addr_err_o(aerr0)
    );

    guvm_instr_mem_responder #(
        .DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(8), .RESP_LAT(1), .MAX_OUT(2), .GNT_STALL(2)
    ) u1 (
        .clk_i(clk), .rst_i(rst), .push_valid_i(push_valid), .push_data_i(push_data),
        .push_ready_o(ready1), .flush_i(flush), .bus(bus1), .fifo_count_o(cnt1),
        .outstanding_o(out1), .underrun_o(und1), .addr_err_o(aerr1)
    );

    logic        o_gnt[2], o_rv[2], o_rdy[2], o_und[2], o_aerr[2];
    logic [31:0] o_rdata[2];
    logic [7:0]  o_cnt[2], o_out[2];
    assign o_gnt[0] = bus0.instr_gnt_o;     assign o_gnt[1] = bus1.instr_gnt_o;
    assign o_rv[0]  = bus0.instr_rvalid_o;  assign o_rv[1]  = bus1.instr_rvalid_o;
    assign o_rdata[0] = bus0.instr_rdata_o; assign o_rdata[1] = bus1.instr_rdata_o;
    assign o_rdy[0] = ready0;  assign o_rdy[1] = ready1;
    assign o_cnt[0] = 8'(cnt0); assign o_cnt[1] = 8'(cnt1);
    assign o_out[0] = 8'(out0); assign o_out[1] = 8'(out1);
    assign o_und[0] = und0;    assign o_und[1] = und1;
    assign o_aerr[0] = aerr0;  assign o_aerr[1] = aerr1;

    function automatic int depth_of(input int k); return (k == 0) ? 4 : 8; endfunction
    function automatic int lat_of(input int k);   return (k == 0) ? 3 : 1; endfunction
    function automatic int maxo_of(input int k);  return 2;                endfunction
    function automatic int stall_of(input int k); return (k == 0) ? 0 : 2; endfunction

    // Model: the FIFO contents and the cycle numbers at which responses fall due.
    logic [31:0] fq[2][$];
    int          due[2][$];
    int          lastg[2];
    bit          gseen[2];
    bit          m_und[2];
    logic [31:0] m_last[2];
    bit          m_expv[2];
    logic [31:0] m_exp[2];
    bit          m_aerr[2];
    int          t = 0;
    bit          armed = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit pv, input logic [31:0] pd,
                        input bit fl, input bit rq, input logic [31:0] ad);
        int          out, sz;
        bit          rv, g, rdy;
        logic [31:0] rd;
        @(negedge clk);
        rst = r; push_valid = pv; push_data = pd; flush = fl; req = rq; addr = ad;
        #1;
        for (int k = 0; k < 2; k++) begin
            while (due[k].size() > 0 && due[k][0] < t) void'(due[k].pop_front());
            out = due[k].size();
            rv  = (out > 0) && (due[k][0] == t);
            sz  = fq[k].size();
            g   = rq && !r && (out < maxo_of(k)) && (!gseen[k] || (t - lastg[k] > stall_of(k)));
            rdy = !r && (sz < depth_of(k));
            rd  = rv ? ((sz > 0) ? fq[k][0] : NOP) : m_last[k];
            if (armed) begin
                chk($sformatf("u%0d.gnt", k),    64'(o_gnt[k]),   64'(g));
                chk($sformatf("u%0d.rvalid", k), 64'(o_rv[k]),    64'(rv));
                chk($sformatf("u%0d.rdata", k),  64'(o_rdata[k]), 64'(rd));
                chk($sformatf("u%0d.ready", k),  64'(o_rdy[k]),   64'(rdy));
                chk($sformatf("u%0d.count", k),  64'(o_cnt[k]),   64'(sz));
                chk($sformatf("u%0d.outst", k),  64'(o_out[k]),   64'(out));
                chk($sformatf("u%0d.underrun", k), 64'(o_und[k]), 64'(m_und[k]));
`ifdef GUVM_SEQ_ADDR_CHECK_EN
                chk($sformatf("u%0d.addr_err", k), 64'(o_aerr[k]), 64'(m_aerr[k]));
`else
                chk($sformatf("u%0d.addr_err", k), 64'(o_aerr[k]), 64'(0));
`endif
            end
            if (r) begin
                fq[k].delete(); due[k].delete();
                gseen[k] = 0; m_und[k] = 0; m_last[k] = '0;
                m_expv[k] = 0; m_exp[k] = '0; m_aerr[k] = 0;
                continue;
            end
            if (rv) begin
                m_last[k] = rd;
                if (sz > 0) void'(fq[k].pop_front());
            end
            if (rv && sz == 0) m_und[k] = 1;
            else if (fl) m_und[k] = 0;
            if (g) begin
                due[k].push_back(t + lat_of(k));
                lastg[k] = t;
                gseen[k] = 1;
            end
            if (fl) fq[k].delete();
            else if (pv && rdy) fq[k].push_back(pd);
            if (fl) begin
                m_expv[k] = 0; m_aerr[k] = 0;
            end else if (g) begin
                if (m_expv[k] && ad != m_exp[k]) m_aerr[k] = 1;
                m_exp[k] = ad + 32'd4; m_expv[k] = 1;
            end
        end
        if (r) armed = 1;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0);
    endtask

    initial begin
        logic [31:0] seq;
        rst = 1; push_valid = 0; push_data = '0; flush = 0; req = 0; addr = '0;
        step(1, 0, '0, 0, 0, '0);
        step(1, 0, '0, 0, 0, '0);

        // Three words then continuous fetch: data in order, then NOP with underrun.
        step(0, 1, 32'hAAAA_0001, 0, 0, '0);
        step(0, 1, 32'hBBBB_0002, 0, 0, '0);
        step(0, 1, 32'hCCCC_0003, 0, 0, '0);
        for (int i = 0; i < 14; i++) step(0, 0, '0, 0, 1, 32'h100 + 32'(4 * i));
        idle(4);

        // Continuous request from empty: exercises outstanding cap and stall spacing.
        step(1, 0, '0, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(0, 0, '0, 0, 1, 32'h40 + 32'(4 * i));
        idle(4);

        // Fill past depth, then drain/refill so the pointers wrap.
        step(1, 0, '0, 0, 0, '0);
        for (int i = 0; i < 9; i++) step(0, 1, 32'hF000_0000 + 32'(i), 0, 0, '0);
        step(0, 1, 32'hF000_0100, 0, 1, 32'h0);
        for (int i = 0; i < 16; i++)
            step(0, 1, 32'hE000_0000 + 32'(i), 0, (i % 2) == 0, 32'h4 + 32'(4 * i));
        idle(6);

        // Flush with words queued and one response in flight, then reset mid-flight.
        step(1, 0, '0, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'hD000_0000 + 32'(i), 0, 0, '0);
        step(0, 0, '0, 0, 1, 32'h300);
        step(0, 1, 32'hD000_00FF, 1, 0, '0);
        idle(4);
        step(0, 1, 32'h1234_5678, 0, 1, 32'h400);
        step(1, 0, '0, 0, 0, '0);
        idle(5);

        // Sequential-address check: jump on the third fetch, flush, then clean run.
        step(1, 0, '0, 0, 0, '0);
        step(0, 0, '0, 0, 1, 32'h100);
        idle(3);
        step(0, 0, '0, 0, 1, 32'h104);
        idle(3);
        step(0, 0, '0, 0, 1, 32'h10C);
        idle(4);
        step(0, 0, '0, 1, 0, '0);
        step(0, 0, '0, 0, 1, 32'h200);
        idle(3);
        step(0, 0, '0, 0, 1, 32'h204);
        idle(4);

        // Randomized traffic.
        seq = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            bit          r, pv, fl, rq;
            logic [31:0] ad;
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 39) == 0);
            pv = ($urandom_range(0, 1) == 1);
            rq = ($urandom_range(0, 9) < 6);
            ad = ($urandom_range(0, 3) != 0) ? seq : ($urandom() & 32'hFFFF_FFFC);
            if (rq) seq = ad + 32'd4;
            step(r, pv, $urandom(), fl, rq, ad);
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
